shift_issue_stage: RTL and testbench

- Registered issue stage directly upstream of the 32-bit arithmetic/logical shift units in the ALU32 execute path.
- Accepts decoded R-type shift instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV).
- Selects the shift amount: the immediate SHAMT field for fixed shifts, RS[M-1:0] for variable shifts.
- Presents the operand, amount and shift type to the shifters through a valid/ready skid buffer, so the shifter side can stall without creating a combinational ready path upstream.

---
 rtl/shift_issue_stage.sv | 219 +++++++++++++++++++++
 tb/tb_shift_issue_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage
//
// Registered issue stage placed in front of the 32-bit shift units in the ALU32
// execute path. It decodes R-type shift instructions (SLL/SRL/SRA and their
// variable forms SLLV/SRLV/SRAV) and picks the shift amount. The amount comes
// from the SHAMT field for fixed shifts and from RS[M-1:0] for variable shifts.
// Operand, amount and shift type go to the shifters through a two-entry skid
// buffer. The shifter side can stall, and IN_READY still comes straight from a
// register.
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST            in   synchronous active-high reset
//   IN_VALID       in   upstream presents an instruction
//   IN_READY       out  stage can accept (state-derived only)
//   FUNCT[5:0]     in   MIPS funct field
//   SHAMT[4:0]     in   instruction shamt field
//   RS[N-1:0]      in   rs register value (variable shift amount source)
//   RT[N-1:0]      in   rt register value (value to be shifted)
//   OUT_VALID      out  OUT_* fields valid
//   OUT_READY      in   shifter side consumes
//   OUT_A[N-1:0]   out  operand to shift
//   OUT_SHIFT_AMT  out  selected shift amount (M bits)
//   OUT_OP[1:0]    out  00=SLL, 01=SRL, 11=SRA
//   ILLEGAL        out  one-cycle pulse after accepting a non-shift funct
//
// Optional build macro: SHIFT_ISSUE_STATS_EN
//   Adds SHIFT_COUNT[15:0] (output transfers) and ILLEGAL_COUNT[15:0]
//   (ILLEGAL pulses). Both are wrapping counters that clear on RST.
// -----------------------------------------------------------------------------
module shift_issue_stage #(
  parameter int N = 32,
  parameter int M = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [5:0]   FUNCT,
  input  logic [4:0]   SHAMT,
  input  logic [N-1:0] RS,
  input  logic [N-1:0] RT,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] OUT_A,
  output logic [M-1:0] OUT_SHIFT_AMT,
  output logic [1:0]   OUT_OP,
  output logic         ILLEGAL
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [15:0]  SHIFT_COUNT,
  output logic [15:0]  ILLEGAL_COUNT
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t         r_state;
  state_t         w_nextState;

  logic [N-1:0]   r_outA;
  logic [M-1:0]   r_outAmt;
  logic [1:0]     r_outOp;
  logic [N-1:0]   r_skidA;
  logic [M-1:0]   r_skidAmt;
  logic [1:0]     r_skidOp;
  logic           r_illegal;

  logic           w_legal;
  logic [M-1:0]   w_amt;
  logic [1:0]     w_op;
  logic           w_accept;
  logic           w_legalAccept;
  logic           w_xfer;
  logic           w_loadOut;
  logic           w_loadSkid;
  logic           w_skidToOut;
  logic           w_unusedRsHigh;

  // RS bits above the amount field never matter for a shift.
  assign w_unusedRsHigh = ^RS[N-1:M];

  // Handshake status comes only from the state register, so a stall on the
  // shifter side never forms a combinational path back to IN_READY.
  assign IN_READY      = (r_state != ST_FULL);
  assign OUT_VALID     = (r_state != ST_EMPTY);
  assign OUT_A         = r_outA;
  assign OUT_SHIFT_AMT = r_outAmt;
  assign OUT_OP        = r_outOp;
  assign ILLEGAL       = r_illegal;

  assign w_accept      = IN_VALID && IN_READY;
  assign w_legalAccept = w_accept && w_legal;
  assign w_xfer        = OUT_VALID && OUT_READY;

  // Funct decode. Variable shifts take the amount from the low bits of RS.
  // Anything else is flagged illegal and never enqueued.
  always_comb begin
    w_legal = 1'b0;
    w_amt   = SHAMT[M-1:0];
    w_op    = 2'b00;
    case (FUNCT)
      6'b000000: begin w_legal = 1'b1; w_amt = SHAMT[M-1:0]; w_op = 2'b00; end
      6'b000010: begin w_legal = 1'b1; w_amt = SHAMT[M-1:0]; w_op = 2'b01; end
      6'b000011: begin w_legal = 1'b1; w_amt = SHAMT[M-1:0]; w_op = 2'b11; end
      6'b000100: begin w_legal = 1'b1; w_amt = RS[M-1:0];    w_op = 2'b00; end
      6'b000110: begin w_legal = 1'b1; w_amt = RS[M-1:0];    w_op = 2'b01; end
      6'b000111: begin w_legal = 1'b1; w_amt = RS[M-1:0];    w_op = 2'b11; end
      default:   begin w_legal = 1'b0; end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and datapath steering. An illegal accept counts as no accept.
  // In FULL, IN_READY is low, so only the drain of the skid entry can occur.
  always_comb begin
    w_nextState = r_state;
    w_loadOut   = 1'b0;
    w_loadSkid  = 1'b0;
    w_skidToOut = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_legalAccept) begin
          w_nextState = ST_ONE;
          w_loadOut   = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_legalAccept && w_xfer) begin
          w_nextState = ST_ONE;
          w_loadOut   = 1'b1;
        end else if (w_legalAccept) begin
          w_nextState = ST_FULL;
          w_loadSkid  = 1'b1;
        end else if (w_xfer) begin
          w_nextState = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_xfer) begin
          w_nextState = ST_ONE;
          w_skidToOut = 1'b1;
        end
      end
      default: begin
        w_nextState = ST_EMPTY;
      end
    endcase
  end

  // Output and skid registers, plus the illegal-funct pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_outA    <= '0;
      r_outAmt  <= '0;
      r_outOp   <= 2'b00;
      r_skidA   <= '0;
      r_skidAmt <= '0;
      r_skidOp  <= 2'b00;
      r_illegal <= 1'b0;
    end else begin
      if (w_skidToOut) begin
        r_outA   <= r_skidA;
        r_outAmt <= r_skidAmt;
        r_outOp  <= r_skidOp;
      end else if (w_loadOut) begin
        r_outA   <= RT;
        r_outAmt <= w_amt;
        r_outOp  <= w_op;
      end
      if (w_loadSkid) begin
        r_skidA   <= RT;
        r_skidAmt <= w_amt;
        r_skidOp  <= w_op;
      end
      r_illegal <= w_accept && !w_legal;
    end
  end

`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] r_shiftCount;
  logic [15:0] r_illegalCount;

  assign SHIFT_COUNT   = r_shiftCount;
  assign ILLEGAL_COUNT = r_illegalCount;

  // The illegal count steps on the same edge that raises ILLEGAL. Both
  // counters wrap naturally at 16 bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shiftCount   <= 16'h0000;
      r_illegalCount <= 16'h0000;
    end else begin
      if (w_xfer) begin
        r_shiftCount <= r_shiftCount + 16'h0001;
      end
      if (w_accept && !w_legal) begin
        r_illegalCount <= r_illegalCount + 16'h0001;
      end
    end
  end
`else
  // Without statistics this build has no counters.
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_stage
//
// Directed self-checking bench for shift_issue_stage. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active rising edge.
// Expected values are hand-computed constants. Statistics checks are compiled
// in when SHIFT_ISSUE_STATS_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_shift_issue_stage;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        outValid;
  logic        outReady;
  logic [31:0] outA;
  logic [4:0]  outShiftAmt;
  logic [1:0]  outOp;
  logic        illegal;
`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] shiftCount;
  logic [15:0] illegalCount;
`endif

  int checks = 0;
  int errors = 0;

  shift_issue_stage #(.N(32), .M(5)) dut (
    .CLK           (clk),
    .RST           (rst),
    .IN_VALID      (inValid),
    .IN_READY      (inReady),
    .FUNCT         (funct),
    .SHAMT         (shamt),
    .RS            (rs),
    .RT            (rt),
    .OUT_VALID     (outValid),
    .OUT_READY     (outReady),
    .OUT_A         (outA),
    .OUT_SHIFT_AMT (outShiftAmt),
    .OUT_OP        (outOp),
    .ILLEGAL       (illegal)
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    .SHIFT_COUNT   (shiftCount),
    .ILLEGAL_COUNT (illegalCount)
`endif
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one instruction (or idle when valid is 0) on the input side.
  task automatic applyStimulus(input logic v, input logic [5:0] f,
                               input logic [4:0] sa, input logic [31:0] s,
                               input logic [31:0] t);
    inValid = v;
    funct   = f;
    shamt   = sa;
    rs      = s;
    rt      = t;
  endtask

  // Reset, then idle: everything at its cleared value.
  task automatic test_reset();
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    outReady = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid actual=%b required=0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready actual=%b required=1", inReady); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal actual=%b required=0", illegal); end
    checks++; if (outA !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_a actual=%h required=00000000", outA); end
    checks++; if (outShiftAmt !== 5'd0) begin errors++; $display("[TB] FAIL reset_amt actual=%0d required=0", outShiftAmt); end
    checks++; if (outOp !== 2'b00) begin errors++; $display("[TB] FAIL reset_op actual=%b required=00", outOp); end
`ifdef SHIFT_ISSUE_STATS_EN
    checks++; if (shiftCount !== 16'h0) begin errors++; $display("[TB] FAIL reset_shift_count actual=%h required=0000", shiftCount); end
    checks++; if (illegalCount !== 16'h0) begin errors++; $display("[TB] FAIL reset_illegal_count actual=%h required=0000", illegalCount); end
`endif
  endtask

  // Fixed SRA: amount from SHAMT, one-cycle latency, drains with ready high.
  task automatic test_sra();
    outReady = 1'b1;
    applyStimulus(1'b1, 6'b000011, 5'd4, 32'h0000_001F, 32'h8000_0000);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL sra_valid actual=%b required=1", outValid); end
    checks++; if (outA !== 32'h8000_0000) begin errors++; $display("[TB] FAIL sra_a actual=%h required=80000000", outA); end
    checks++; if (outShiftAmt !== 5'd4) begin errors++; $display("[TB] FAIL sra_amt actual=%0d required=4", outShiftAmt); end
    checks++; if (outOp !== 2'b11) begin errors++; $display("[TB] FAIL sra_op actual=%b required=11", outOp); end
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL sra_drained actual=%b required=0", outValid); end
  endtask

  // Variable SRLV: amount from RS low bits, SHAMT and RS upper bits ignored.
  task automatic test_srlv();
    outReady = 1'b1;
    applyStimulus(1'b1, 6'b000110, 5'd9, 32'hFFFF_FFE3, 32'h1234_5678);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    checks++; if (outShiftAmt !== 5'd3) begin errors++; $display("[TB] FAIL srlv_amt actual=%0d required=3", outShiftAmt); end
    checks++; if (outOp !== 2'b01) begin errors++; $display("[TB] FAIL srlv_op actual=%b required=01", outOp); end
    checks++; if (outA !== 32'h1234_5678) begin errors++; $display("[TB] FAIL srlv_a actual=%h required=12345678", outA); end
    @(negedge clk);
  endtask

  // Three SLLs against a stalled shifter, then release: order 1,2,3 kept.
  task automatic test_back_to_back();
    outReady = 1'b0;
    applyStimulus(1'b1, 6'b000000, 5'd1, 32'h0, 32'h0000_0011);
    @(negedge clk);
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_one actual=%b required=1", inReady); end
    checks++; if (outShiftAmt !== 5'd1) begin errors++; $display("[TB] FAIL b2b_first actual=%0d required=1", outShiftAmt); end
    applyStimulus(1'b1, 6'b000000, 5'd2, 32'h0, 32'h0000_0022);
    @(negedge clk);
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_full actual=%b required=0", inReady); end
    applyStimulus(1'b1, 6'b000000, 5'd3, 32'h0, 32'h0000_0033);
    @(negedge clk);
    checks++; if (outShiftAmt !== 5'd1 || outA !== 32'h0000_0011) begin errors++; $display("[TB] FAIL b2b_stall_hold actual=%0d/%h required=1/00000011", outShiftAmt, outA); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_third_held actual=%b required=0", inReady); end
    outReady = 1'b1;
    @(negedge clk);
    checks++; if (outShiftAmt !== 5'd2 || outA !== 32'h0000_0022) begin errors++; $display("[TB] FAIL b2b_second actual=%0d/%h required=2/00000022", outShiftAmt, outA); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_drain actual=%b required=1", inReady); end
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    checks++; if (outShiftAmt !== 5'd3 || outA !== 32'h0000_0033 || outValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_third actual=%0d/%h/%b required=3/00000033/1", outShiftAmt, outA, outValid); end
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_duplicate actual=%b required=0", outValid); end
  endtask

  // Illegal funct: one-cycle pulse, nothing enqueued, held entry untouched.
  task automatic test_illegal();
    outReady = 1'b1;
    applyStimulus(1'b1, 6'b100000, 5'd7, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse actual=%b required=1", illegal); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_no_entry actual=%b required=0", outValid); end
`ifdef SHIFT_ISSUE_STATS_EN
    checks++; if (illegalCount !== 16'd1) begin errors++; $display("[TB] FAIL illegal_count actual=%0d required=1", illegalCount); end
`endif
    @(negedge clk);
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_one_cycle actual=%b required=0", illegal); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_still_empty actual=%b required=0", outValid); end
    // Illegal while ONE: state must not advance to FULL.
    outReady = 1'b0;
    applyStimulus(1'b1, 6'b000000, 5'd5, 32'h0, 32'h0000_0055);
    @(negedge clk);
    applyStimulus(1'b1, 6'b101010, 5'd6, 32'h0, 32'h0000_0066);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_in_one_pulse actual=%b required=1", illegal); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL illegal_in_one_ready actual=%b required=1", inReady); end
    checks++; if (outShiftAmt !== 5'd5 || outA !== 32'h0000_0055) begin errors++; $display("[TB] FAIL illegal_in_one_hold actual=%0d/%h required=5/00000055", outShiftAmt, outA); end
    outReady = 1'b1;
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_in_one_drain actual=%b required=0", outValid); end
  endtask

  // Reset while FULL: stage empties and the skid entry is never emitted.
  task automatic test_reset_mid_full();
    outReady = 1'b0;
    applyStimulus(1'b1, 6'b000111, 5'd0, 32'h0000_000A, 32'h0000_00AA);
    @(negedge clk);
    applyStimulus(1'b1, 6'b000111, 5'd0, 32'h0000_000B, 32'h0000_00BB);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL midfull_reached actual=%b required=0", inReady); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("[TB] FAIL midfull_empty actual=%b/%b required=0/1", outValid, inReady); end
    checks++; if (outA !== 32'h0 || outShiftAmt !== 5'd0 || outOp !== 2'b00) begin errors++; $display("[TB] FAIL midfull_cleared actual=%h/%0d/%b required=0/0/00", outA, outShiftAmt, outOp); end
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL midfull_skid_dropped actual=%b required=0", outValid); end
  endtask

`ifdef SHIFT_ISSUE_STATS_EN
  // Shift counter wrap: 65535 transfers reach FFFF, one more wraps to 0.
  task automatic test_stats_wrap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    outReady = 1'b1;
    applyStimulus(1'b1, 6'b000000, 5'd1, 32'h0, 32'h1);
    repeat (65535) @(negedge clk);
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (shiftCount !== 16'hFFFF) begin errors++; $display("[TB] FAIL stats_full actual=%h required=ffff", shiftCount); end
    checks++; if (illegalCount !== 16'h0) begin errors++; $display("[TB] FAIL stats_illegal_clear actual=%h required=0000", illegalCount); end
    applyStimulus(1'b1, 6'b000000, 5'd1, 32'h0, 32'h1);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (shiftCount !== 16'h0000) begin errors++; $display("[TB] FAIL stats_wrap actual=%h required=0000", shiftCount); end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    outReady = 1'b0;
    applyStimulus(1'b0, 6'h00, 5'd0, 32'h0, 32'h0);
    test_reset();
    test_sra();
    test_srlv();
    test_back_to_back();
    test_illegal();
    test_reset_mid_full();
`ifdef SHIFT_ISSUE_STATS_EN
    test_stats_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
